// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, per-request handshake pulses
// (write acknowledge, overflow, underflow) and count-derived level flags.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8    // power of two, >= 4, so pointers wrap naturally
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [AW-1:0]         wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0]         count_q,     count_d;
    logic [FIFO_WIDTH-1:0] data_out_q,  data_out_d;
    logic                  wr_ack_q,    wr_ack_d;
    logic                  overflow_q,  overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  wr_accept;
    logic                  rd_accept;

    // Level flags come straight from the registered count, so they move in
    // the same cycle as count with no extra register stage.
    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q == CW'(FIFO_DEPTH - 1));
    assign almostempty = (count_q == CW'(1));

    // A write into a full FIFO and a read from an empty one are rejected;
    // everything else (including simultaneous read and write) is accepted.
    assign wr_accept = wr_en & ~full;
    assign rd_accept = rd_en & ~empty;

    assign data_out  = data_out_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Next-state for pointers, count, read data and the per-request pulses.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        wr_ack_d    = wr_accept;
        overflow_d  = wr_en & full;
        underflow_d = rd_en & empty;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            data_out_d = mem[rd_ptr_q];
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and output registers; reset discards queued data at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array, never cleared; stale words cannot be read once count is zero.
    always_ff @(posedge clk) begin
        if (wr_accept && !rst) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: directed stimulus queues hand-computed
// expected outputs; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_sync_fifo;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] data_out;
    logic        wr_ack;
    logic        overflow;
    logic        underflow;
    logic        full;
    logic        empty;
    logic        almostfull;
    logic        almostempty;

    sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .empty       (empty),
        .almostfull  (almostfull),
        .almostempty (almostempty)
    );

    typedef struct {
        int          due;
        logic        ack;
        logic        ovf;
        logic        udf;
        logic        full;
        logic        empty;
        logic        af;
        logic        ae;
        logic [15:0] dout;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
        if (act !== exp_v) begin
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp_v, cyc);
            n_err++;
        end
    endtask

    // Monitor: at each falling edge compare every expectation that is due now.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                n_vec++;
                if (e.due < cyc) begin
                    $display("FAIL stale_expectation: due %0d checked at %0d", e.due, cyc);
                    n_err++;
                end else begin
                    $display("vec %0d cyc %0d: wr_ack=%b ovf=%b udf=%b full=%b empty=%b af=%b ae=%b dout=%h",
                             n_vec, cyc, wr_ack, overflow, underflow, full, empty,
                             almostfull, almostempty, data_out);
                    chk("wr_ack",      16'(wr_ack),      16'(e.ack));
                    chk("overflow",    16'(overflow),    16'(e.ovf));
                    chk("underflow",   16'(underflow),   16'(e.udf));
                    chk("full",        16'(full),        16'(e.full));
                    chk("empty",       16'(empty),       16'(e.empty));
                    chk("almostfull",  16'(almostfull),  16'(e.af));
                    chk("almostempty", 16'(almostempty), 16'(e.ae));
                    chk("data_out",    data_out,         e.dout);
                end
            end
        end
    end

    // Drive one cycle of inputs and queue what must be seen after the next edge.
    task automatic step(input logic r, input logic w, input logic rd, input logic [15:0] din,
                        input logic e_ack, input logic e_ovf, input logic e_udf,
                        input logic e_full, input logic e_empty, input logic e_af,
                        input logic e_ae, input logic [15:0] e_dout);
        exp_t e;
        @(posedge clk);
        #2;
        rst     = r;
        wr_en   = w;
        rd_en   = rd;
        data_in = din;
        e.due   = cyc + 1;
        e.ack   = e_ack;
        e.ovf   = e_ovf;
        e.udf   = e_udf;
        e.full  = e_full;
        e.empty = e_empty;
        e.af    = e_af;
        e.ae    = e_ae;
        e.dout  = e_dout;
        q.push_back(e);
    endtask

    // Short reset pulse strictly between a falling and the next rising edge.
    task automatic reset_pulse();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b1;
        #1;
        rst   = 1'b0;
        e.due   = cyc + 1;
        e.ack   = 1'b0;
        e.ovf   = 1'b0;
        e.udf   = 1'b0;
        e.full  = 1'b0;
        e.empty = 1'b1;
        e.af    = 1'b0;
        e.ae    = 1'b0;
        e.dout  = 16'h0000;
        q.push_back(e);
    endtask

    initial begin
        logic [15:0] prev;
        rst     = 1'b1;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        data_in = 16'h1234;

        // Reset held two cycles with both requests active.
        repeat (2) step(1, 1, 1, 16'h1234, 0, 0, 0, 0, 1, 0, 0, 16'h0000);

        // Fill 1..8.
        for (int i = 1; i <= 8; i++)
            step(0, 1, 0, 16'(i), 1, 0, 0, i == 8, 0, i == 7, i == 1, 16'h0000);

        // Overflow attempt.
        step(0, 1, 0, 16'hDEAD, 0, 1, 0, 1, 0, 0, 0, 16'h0000);

        // Drain 1..8 in order.
        for (int i = 1; i <= 8; i++)
            step(0, 0, 1, 16'h0000, 0, 0, 0, 0, i == 8, i == 1, i == 7, 16'(i));

        // Underflow: data_out holds last word.
        step(0, 0, 1, 16'h0000, 0, 0, 1, 0, 1, 0, 0, 16'h0008);

        // Simultaneous read/write while empty.
        step(0, 1, 1, 16'h00AA, 1, 0, 1, 0, 0, 0, 1, 16'h0008);

        // Top up to full with B1..B7.
        for (int j = 1; j <= 7; j++)
            step(0, 1, 0, 16'h00B0 + 16'(j), 1, 0, 0, j == 7, 0, j == 6, 0, 16'h0008);

        // Simultaneous read/write while full: read wins, oldest word out.
        step(0, 1, 1, 16'hDEAD, 0, 1, 0, 0, 0, 1, 0, 16'h00AA);

        // Drain remaining B1..B7; 0xDEAD must never appear.
        for (int j = 1; j <= 7; j++)
            step(0, 0, 1, 16'h0000, 0, 0, 0, 0, j == 7, 0, j == 6, 16'h00B0 + 16'(j));

        // Alternating write/read across pointer wrap.
        prev = 16'h00B7;
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 0, 16'h0100 + 16'(k), 1, 0, 0, 0, 0, 0, 1, prev);
            step(0, 0, 1, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 16'h0100 + 16'(k));
            prev = 16'h0100 + 16'(k);
        end

        // Three writes, then an asynchronous reset pulse between edges.
        for (int j = 1; j <= 3; j++)
            step(0, 1, 0, 16'h0200 + 16'(j), 1, 0, 0, 0, 0, 0, j == 1, 16'h0109);
        reset_pulse();

        // Queued words are gone: a read underflows.
        step(0, 0, 1, 16'h0000, 0, 0, 1, 0, 1, 0, 0, 16'h0000);

        step(0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 16'h0000);

        for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
        if (q.size() > 0) begin
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
            n_err++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

- Synchronous single-clock FIFO: the design under test that drives every signal the FIFO bench monitor samples.
- Buffers write data, returns it in order on read requests, and reports status:
  - per-cycle: write acknowledge, overflow, underflow
  - level-based: full, empty, almostfull, almostempty
- Sits between a producer and a consumer on the same clock.
- All outputs are stable by the falling clock edge, where the bench samples them.

## Interface
- FIFO_WIDTH, 16, data word width in bits
- FIFO_DEPTH, 8, number of storage entries; must be a power of two, ≥ 4
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- data_in  in  FIFO_WIDTH  write data, captured when a write is accepted
- wr_en  in  1  write request
- rd_en  in  1  read request
- data_out  out  FIFO_WIDTH  registered read data
- wr_ack  out  1  registered; previous-edge write was accepted
- overflow  out  1  registered; previous-edge write was rejected because FIFO was full
- underflow  out  1  registered; previous-edge read was rejected because FIFO was empty
- full  out  1  combinational, count == FIFO_DEPTH
- empty  out  1  combinational, count == 0
- almostfull  out  1  combinational, count == FIFO_DEPTH-1
- almostempty  out  1  combinational, count == 1

## Operation
State:
- wr_ptr and rd_ptr, each $clog2(FIFO_DEPTH) bits; they wrap modulo FIFO_DEPTH with no explicit compare.
- count, $clog2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- mem[FIFO_DEPTH].

Reset (asynchronous, rst=1):
- wr_ptr, rd_ptr and count are cleared to 0.
- data_out, wr_ack, overflow and underflow are cleared to 0.
- Therefore empty=1 and full, almostfull, almostempty = 0.
- mem is not cleared; its stale contents are unobservable.
- A reset asserted mid-operation discards all queued data immediately, not waiting for a clock edge.

Write, evaluated per rising edge with rst=0:
- wr_en & !full: mem[wr_ptr] ← data_in, wr_ptr++, wr_ack ← 1, overflow ← 0.
- wr_en & full: no storage, wr_ack ← 0, overflow ← 1.
- !wr_en: wr_ack ← 0, overflow ← 0.

Read, evaluated per rising edge:
- rd_en & !empty: data_out ← mem[rd_ptr], rd_ptr++, underflow ← 0.
- rd_en & empty: data_out holds, underflow ← 1.
- !rd_en: data_out holds, underflow ← 0.

Count update:
- +1 if only the write is accepted.
- −1 if only the read is accepted.
- Unchanged if both or neither is accepted.

Simultaneous wr_en & rd_en:
- Not full and not empty: both are accepted and count is unchanged.
- Full: the read is accepted; the write is rejected (overflow ← 1, wr_ack ← 0); count → DEPTH−1.
- Empty: the write is accepted (wr_ack ← 1); the read is rejected (underflow ← 1, data_out holds); count → 1.
- There is no write-through: data written at an edge is never read at the same edge.

## Timing
- Write-to-read latency: a word written at edge N is readable at edge N+1 at the earliest, and appears on data_out after that edge.
- Read latency: data_out is valid one edge after the read is accepted and holds until the next accepted read or reset.
- wr_ack, overflow and underflow are single-cycle pulses per request. They stay asserted across consecutive cycles only while their condition repeats.
- Status flags change in the same cycle as count, right after the rising edge; no extra register stage.
- Outputs are settled before the next falling edge; the bench samples at negedge.

## Test plan
- Reset: assert rst for 2 cycles with wr_en=rd_en=1.
  - Required: empty=1, full=0, data_out=0, wr_ack=overflow=underflow=0 throughout.
- Fill: from reset, write 0x0001..0x0008 on consecutive cycles.
  - Required: wr_ack=1 after each edge; almostfull=1 after the 7th write; full=1 after the 8th.
- Overflow: 9th write of 0xDEAD while full.
  - Required: overflow=1, wr_ack=0, full stays 1; later reads never return 0xDEAD.
- Drain and underflow: read 8 times.
  - Required: data_out=0x0001..0x0008 in order; almostempty=1 after the 7th read; empty=1 after the 8th.
  - A 9th read gives underflow=1 and data_out holds 0x0008.
- Simultaneous at boundaries:
  - When empty, wr_en=rd_en=1 with 0x00AA → wr_ack=1, underflow=1, count=1 (almostempty=1).
  - When full, wr_en=rd_en=1 → overflow=1, the oldest word appears on data_out, almostfull=1.
- Wrap-around and mid-op reset:
  - Run 20 cycles of alternating write/read with values 0x0100+i → every read returns the matching value across pointer wrap.
  - Then write 3 words and pulse rst between clock edges → empty=1 immediately; a following read gives underflow=1.
